// File: rtl/bp_fe_pkg.sv
// Front-end shared types for the LCE fill-packet arbiter.
package bp_fe_pkg;

  localparam int unsigned fe_lce_chan_lp = 3;

  typedef enum logic [1:0] {
    e_fe_pkt_data = 2'd0,
    e_fe_pkt_tag  = 2'd1,
    e_fe_pkt_stat = 2'd2
  } bp_fe_lce_pkt_type_e;

  typedef enum logic {
    e_idle  = 1'b0,
    e_grant = 1'b1
  } bp_fe_lce_arb_state_e;

  // Round-robin pick: search starts at the channel after base, base itself last.
  function automatic bp_fe_lce_pkt_type_e rr_pick(input logic [2:0] v,
                                                  input bp_fe_lce_pkt_type_e base);
    rr_pick = base;
    case (base)
      e_fe_pkt_data: begin
        if (v[1])      rr_pick = e_fe_pkt_tag;
        else if (v[2]) rr_pick = e_fe_pkt_stat;
        else if (v[0]) rr_pick = e_fe_pkt_data;
      end
      e_fe_pkt_tag: begin
        if (v[2])      rr_pick = e_fe_pkt_stat;
        else if (v[0]) rr_pick = e_fe_pkt_data;
        else if (v[1]) rr_pick = e_fe_pkt_tag;
      end
      default: begin
        if (v[0])      rr_pick = e_fe_pkt_data;
        else if (v[1]) rr_pick = e_fe_pkt_tag;
        else if (v[2]) rr_pick = e_fe_pkt_stat;
      end
    endcase
  endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid -> valid/yumi buffer. Ready is held low during reset.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  output logic               full_o,
  input  logic               yumi_i
);

  logic [1:0][width_p-1:0] r_mem;
  logic                    r_rptr, r_wptr;
  logic [1:0]              r_cnt;
  logic                    w_enq, w_deq;

  assign full_o  = (r_cnt == 2'd2);
  assign v_o     = (r_cnt != 2'd0);
  assign ready_o = ~full_o & ~reset_i;
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  // Occupancy and pointer update; enq+deq in one cycle leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt  <= '0;
      r_rptr <= 1'b0;
      r_wptr <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 2'(w_enq) - 2'(w_deq);
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
    end
  end

  // Storage write; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bp_fe_lce_pkt_arbiter.sv
// Serializes LCE data/tag/stat fill packets onto one port with a locked
// round-robin grant. The next lock is chosen a cycle ahead from the
// post-dequeue/post-enqueue buffer state, so grants stream without bubbles.
module bp_fe_lce_pkt_arbiter
  import bp_fe_pkg::*;
#(
  parameter int data_pkt_width_p = 16,
  parameter int tag_pkt_width_p  = 12,
  parameter int stat_pkt_width_p = 8,
  localparam int pkt_w01_lp      = (data_pkt_width_p > tag_pkt_width_p) ? data_pkt_width_p : tag_pkt_width_p,
  localparam int pkt_width_lp    = (pkt_w01_lp > stat_pkt_width_p) ? pkt_w01_lp : stat_pkt_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [data_pkt_width_p-1:0] data_mem_pkt_i,
  input  logic                        data_mem_pkt_v_i,
  output logic                        data_mem_pkt_ready_o,
  input  logic [tag_pkt_width_p-1:0]  tag_mem_pkt_i,
  input  logic                        tag_mem_pkt_v_i,
  output logic                        tag_mem_pkt_ready_o,
  input  logic [stat_pkt_width_p-1:0] stat_mem_pkt_i,
  input  logic                        stat_mem_pkt_v_i,
  output logic                        stat_mem_pkt_ready_o,
  output logic [pkt_width_lp-1:0]     pkt_o,
  output logic [1:0]                  pkt_type_o,
  output logic                        pkt_v_o,
  input  logic                        pkt_yumi_i,
  output logic                        idle_o
);

  bp_fe_lce_arb_state_e r_state, w_state_n;
  bp_fe_lce_pkt_type_e  r_lock, w_lock_n;
  bp_fe_lce_pkt_type_e  r_last_grant, w_last_grant_n;

  logic [2:0]                   w_v, w_full, w_enq, w_deq, w_post;
  logic [2:0][pkt_width_lp-1:0] w_pkt_ext;
  logic [data_pkt_width_p-1:0]  w_data_pkt;
  logic [tag_pkt_width_p-1:0]   w_tag_pkt;
  logic [stat_pkt_width_p-1:0]  w_stat_pkt;
  logic                         w_yumi;

  bsg_two_fifo #(.width_p(data_pkt_width_p)) u_data_fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .data_i(data_mem_pkt_i), .v_i(data_mem_pkt_v_i), .ready_o(data_mem_pkt_ready_o),
    .data_o(w_data_pkt), .v_o(w_v[0]), .full_o(w_full[0]), .yumi_i(w_deq[0])
  );

  bsg_two_fifo #(.width_p(tag_pkt_width_p)) u_tag_fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .data_i(tag_mem_pkt_i), .v_i(tag_mem_pkt_v_i), .ready_o(tag_mem_pkt_ready_o),
    .data_o(w_tag_pkt), .v_o(w_v[1]), .full_o(w_full[1]), .yumi_i(w_deq[1])
  );

  bsg_two_fifo #(.width_p(stat_pkt_width_p)) u_stat_fifo (
    .clk_i(clk_i), .reset_i(reset_i),
    .data_i(stat_mem_pkt_i), .v_i(stat_mem_pkt_v_i), .ready_o(stat_mem_pkt_ready_o),
    .data_o(w_stat_pkt), .v_o(w_v[2]), .full_o(w_full[2]), .yumi_i(w_deq[2])
  );

  assign w_enq = {stat_mem_pkt_v_i & stat_mem_pkt_ready_o,
                  tag_mem_pkt_v_i  & tag_mem_pkt_ready_o,
                  data_mem_pkt_v_i & data_mem_pkt_ready_o};

  assign w_pkt_ext[0] = pkt_width_lp'(w_data_pkt);
  assign w_pkt_ext[1] = pkt_width_lp'(w_tag_pkt);
  assign w_pkt_ext[2] = pkt_width_lp'(w_stat_pkt);

  // Output side: the locked channel drives the port; zeros when idle.
  assign pkt_v_o    = (r_state == e_grant) & ~reset_i;
  assign pkt_type_o = pkt_v_o ? r_lock : 2'd0;
  assign pkt_o      = pkt_v_o ? w_pkt_ext[r_lock] : '0;
  assign idle_o     = ~|w_v;
  assign w_yumi     = pkt_yumi_i & pkt_v_o;
  assign w_deq      = w_yumi ? (3'b001 << r_lock) : 3'b000;
  // Channels holding a packet next cycle.
  assign w_post     = w_enq | w_full | (w_v & ~w_deq);

  // Next state: lock the next grant one cycle ahead on wake-up or on yumi.
  always_comb begin
    w_state_n      = r_state;
    w_lock_n       = r_lock;
    w_last_grant_n = r_last_grant;
    case (r_state)
      e_idle: begin
        if (|w_post) begin
          w_state_n = e_grant;
          w_lock_n  = rr_pick(w_post, r_last_grant);
        end
      end
      default: begin
        if (w_yumi) begin
          w_last_grant_n = r_lock;
          if (|w_post) w_lock_n  = rr_pick(w_post, r_lock);
          else         w_state_n = e_idle;
        end
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= e_idle;
      r_lock       <= e_fe_pkt_data;
      r_last_grant <= e_fe_pkt_stat;
    end else begin
      r_state      <= w_state_n;
      r_lock       <= w_lock_n;
      r_last_grant <= w_last_grant_n;
    end
  end

`ifndef SYNTHESIS
  // Consumer must not yumi an empty port.
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(pkt_yumi_i && !pkt_v_o)) else $error("pkt_yumi_i asserted without pkt_v_o");
  end
`endif

endmodule

// File: tb/tb_bp_fe_lce_pkt_arbiter.sv
// Directed bench for bp_fe_lce_pkt_arbiter with per-channel scoreboards.
module tb_bp_fe_lce_pkt_arbiter;
  localparam int DW = 16, TW = 12, SW = 8, PW = 16;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [DW-1:0] data_mem_pkt_i = '0;
  logic          data_mem_pkt_v_i = 1'b0, data_mem_pkt_ready_o;
  logic [TW-1:0] tag_mem_pkt_i = '0;
  logic          tag_mem_pkt_v_i = 1'b0, tag_mem_pkt_ready_o;
  logic [SW-1:0] stat_mem_pkt_i = '0;
  logic          stat_mem_pkt_v_i = 1'b0, stat_mem_pkt_ready_o;
  logic [PW-1:0] pkt_o;
  logic [1:0]    pkt_type_o;
  logic          pkt_v_o, idle_o;
  logic          pkt_yumi_i = 1'b0;

  int n_cmp = 0, n_err = 0;
  logic [15:0] d_src[$], t_src[$], s_src[$];
  logic [15:0] sb0[$], sb1[$], sb2[$];
  logic [1:0]  typelog[$];

  bp_fe_lce_pkt_arbiter #(.data_pkt_width_p(DW), .tag_pkt_width_p(TW), .stat_pkt_width_p(SW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .data_mem_pkt_i(data_mem_pkt_i), .data_mem_pkt_v_i(data_mem_pkt_v_i), .data_mem_pkt_ready_o(data_mem_pkt_ready_o),
    .tag_mem_pkt_i(tag_mem_pkt_i), .tag_mem_pkt_v_i(tag_mem_pkt_v_i), .tag_mem_pkt_ready_o(tag_mem_pkt_ready_o),
    .stat_mem_pkt_i(stat_mem_pkt_i), .stat_mem_pkt_v_i(stat_mem_pkt_v_i), .stat_mem_pkt_ready_o(stat_mem_pkt_ready_o),
    .pkt_o(pkt_o), .pkt_type_o(pkt_type_o), .pkt_v_o(pkt_v_o), .pkt_yumi_i(pkt_yumi_i), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present the head of each sender queue.
  task automatic drive();
    data_mem_pkt_v_i = (d_src.size() != 0);
    tag_mem_pkt_v_i  = (t_src.size() != 0);
    stat_mem_pkt_v_i = (s_src.size() != 0);
    data_mem_pkt_i   = (d_src.size() != 0) ? d_src[0][DW-1:0] : '0;
    tag_mem_pkt_i    = (t_src.size() != 0) ? t_src[0][TW-1:0] : '0;
    stat_mem_pkt_i   = (s_src.size() != 0) ? s_src[0][SW-1:0] : '0;
  endtask

  // Monitor handshakes at negedge, then advance to just after the next posedge.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    if (data_mem_pkt_v_i && data_mem_pkt_ready_o) sb0.push_back(d_src.pop_front());
    if (tag_mem_pkt_v_i  && tag_mem_pkt_ready_o)  sb1.push_back(t_src.pop_front());
    if (stat_mem_pkt_v_i && stat_mem_pkt_ready_o) sb2.push_back(s_src.pop_front());
    if (pkt_yumi_i) begin
      check("pkt_v_on_yumi", 32'(pkt_v_o), 32'd1);
      typelog.push_back(pkt_type_o);
      case (pkt_type_o)
        2'd0: if (sb0.size() == 0) check("sb_data_nonempty", 32'(sb0.size()), 32'd1);
              else begin e = sb0.pop_front(); check("pkt_data", 32'(pkt_o), 32'(e)); end
        2'd1: if (sb1.size() == 0) check("sb_tag_nonempty", 32'(sb1.size()), 32'd1);
              else begin e = sb1.pop_front(); check("pkt_tag", 32'(pkt_o), 32'(e)); end
        2'd2: if (sb2.size() == 0) check("sb_stat_nonempty", 32'(sb2.size()), 32'd1);
              else begin e = sb2.pop_front(); check("pkt_stat", 32'(pkt_o), 32'(e)); end
        default: check("pkt_type_range", 32'(pkt_type_o), 32'd0);
      endcase
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic reset_pulse();
    reset_i = 1'b1;
    #1;
    check("rst_rdy_d", 32'(data_mem_pkt_ready_o), 32'd0);
    check("rst_rdy_t", 32'(tag_mem_pkt_ready_o), 32'd0);
    check("rst_rdy_s", 32'(stat_mem_pkt_ready_o), 32'd0);
    check("rst_pkt_v", 32'(pkt_v_o), 32'd0);
    check("rst_pkt_o", 32'(pkt_o), 32'd0);
    check("rst_type", 32'(pkt_type_o), 32'd0);
    tick();
    sb0.delete(); sb1.delete(); sb2.delete();
    reset_i = 1'b0;
    #1;
    check("post_rst_pkt_v", 32'(pkt_v_o), 32'd0);
    check("post_rst_idle", 32'(idle_o), 32'd1);
    check("post_rst_rdy", 32'({data_mem_pkt_ready_o, tag_mem_pkt_ready_o, stat_mem_pkt_ready_o}), 32'h7);
  endtask

  initial begin
    // Reset
    tick();
    reset_pulse();

    // Single data packet, latency 1, idle after yumi
    d_src.push_back(16'h00A5); drive(); #1;
    check("a_rdy", 32'(data_mem_pkt_ready_o), 32'd1);
    tick(); #1;
    check("a_v", 32'(pkt_v_o), 32'd1);
    check("a_type", 32'(pkt_type_o), 32'd0);
    check("a_pkt", 32'(pkt_o), 32'h00A5);
    check("a_idle_busy", 32'(idle_o), 32'd0);
    pkt_yumi_i = 1'b1; tick(); pkt_yumi_i = 1'b0; #1;
    check("a_idle", 32'(idle_o), 32'd1);
    check("a_v_off", 32'(pkt_v_o), 32'd0);
    check("a_pkt_off", 32'(pkt_o), 32'd0);

    // Fairness: 3 packets per channel, yumi every cycle
    reset_pulse();
    typelog.delete();
    for (int i = 1; i <= 3; i++) begin
      d_src.push_back(16'h1100 + 16'(i));
      t_src.push_back(16'h0200 + 16'(i));
      s_src.push_back(16'h0030 + 16'(i));
    end
    drive();
    tick(); tick(); #1;
    check("b_full_rdy_d", 32'(data_mem_pkt_ready_o), 32'd0);
    pkt_yumi_i = 1'b1;
    repeat (9) tick();
    pkt_yumi_i = 1'b0; #1;
    check("b_count", 32'(typelog.size()), 32'd9);
    for (int i = 0; i < 9 && i < typelog.size(); i++)
      check($sformatf("b_seq%0d", i), 32'(typelog[i]), 32'(i % 3));
    check("b_idle", 32'(idle_o), 32'd1);

    // Grant lock: data held 5 cycles while tag arrives
    d_src.push_back(16'h0DD1); drive();
    tick();
    t_src.push_back(16'h02A1); drive();
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("c_type%0d", i), 32'(pkt_type_o), 32'd0);
      check($sformatf("c_pkt%0d", i), 32'(pkt_o), 32'h0DD1);
      tick();
    end
    pkt_yumi_i = 1'b1; tick(); pkt_yumi_i = 1'b0; #1;
    check("c_tag_v", 32'(pkt_v_o), 32'd1);
    check("c_tag_type", 32'(pkt_type_o), 32'd1);
    check("c_tag_pkt", 32'(pkt_o), 32'h02A1);
    pkt_yumi_i = 1'b1; tick(); pkt_yumi_i = 1'b0; #1;
    check("c_idle", 32'(idle_o), 32'd1);

    // Backpressure on one channel, order preserved
    d_src.push_back(16'h0D01); d_src.push_back(16'h0D02); d_src.push_back(16'h0D03); drive();
    tick(); tick(); #1;
    check("d_rdy_full", 32'(data_mem_pkt_ready_o), 32'd0);
    tick(); #1;
    check("d_rdy_still", 32'(data_mem_pkt_ready_o), 32'd0);
    check("d_pending", 32'(d_src.size()), 32'd1);
    check("d_head", 32'(pkt_o), 32'h0D01);
    pkt_yumi_i = 1'b1; tick(); #1;
    check("d_rdy_back", 32'(data_mem_pkt_ready_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      pkt_yumi_i = pkt_v_o;
      tick();
      #1;
    end
    pkt_yumi_i = 1'b0; #1;
    check("d_sent", 32'(d_src.size()), 32'd0);
    check("d_drained", 32'(sb0.size()), 32'd0);
    check("d_idle", 32'(idle_o), 32'd1);

    // Reset with 2 tag + 1 stat buffered
    t_src.push_back(16'h02B1); t_src.push_back(16'h02B2); s_src.push_back(16'h003C); drive();
    tick(); tick(); #1;
    check("e_busy", 32'(idle_o), 32'd0);
    reset_pulse();

    // Narrow stat packet zero-extended
    s_src.push_back(16'h00A7); drive();
    tick(); #1;
    check("f_v", 32'(pkt_v_o), 32'd1);
    check("f_type", 32'(pkt_type_o), 32'd2);
    check("f_pkt", 32'(pkt_o), 32'h00A7);
    pkt_yumi_i = 1'b1; tick(); pkt_yumi_i = 1'b0; #1;
    check("f_idle", 32'(idle_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_fe_lce_pkt_arbiter.md
# bp_fe_lce_pkt_arbiter

Serializes the three LCE→I$ fill channels (data, tag and stat mem packets) onto one packet port that feeds the I$ packet engine in `bp_fe_mem`. Each channel is decoupled by a 2-entry buffer. A locked round-robin arbiter then grants one packet per cycle. Packet order is preserved within a channel; order across channels is set by arbitration only.

## Interface
Parameters:
- `data_pkt_width_p`, none: width of `cache_data_mem_pkt` from `bp_params_p`.
- `tag_pkt_width_p`, none: width of `cache_tag_mem_pkt`.
- `stat_pkt_width_p`, none: width of `cache_stat_mem_pkt`.
- `pkt_width_lp`, localparam: max of the three widths.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `data_mem_pkt_i`  in  `data_pkt_width_p`  data packet.
- `data_mem_pkt_v_i`  in  1  data packet valid.
- `data_mem_pkt_ready_o`  out  1  data buffer not full.
- `tag_mem_pkt_i`, `tag_mem_pkt_v_i`, `tag_mem_pkt_ready_o`: same rules as data; width `tag_pkt_width_p`.
- `stat_mem_pkt_i`, `stat_mem_pkt_v_i`, `stat_mem_pkt_ready_o`: same rules as data; width `stat_pkt_width_p`.
- `pkt_o`  out  `pkt_width_lp`  granted packet, zero-extended at MSBs.
- `pkt_type_o`  out  2  `bp_fe_lce_pkt_type_e`: 0 data, 1 tag, 2 stat.
- `pkt_v_o`  out  1  `pkt_o`/`pkt_type_o` valid.
- `pkt_yumi_i`  in  1  consumer accepts; legal only when `pkt_v_o`.
- `idle_o`  out  1  all three buffers empty.

## Operation
- Inputs use ready/valid. A transfer happens when `v_i & ready_o`. `ready_o` never depends on `v_i`. `ready_o` = buffer not full.
- Output uses valid/yumi. A packet is dequeued from its buffer when `pkt_yumi_i` is high.
- Round-robin order is data → tag → stat → data. The search starts one after `last_grant_r`.
- Grant lock:
  - When `pkt_v_o` rises, the granted channel is latched in `lock_r`.
  - Grant, `pkt_o` and `pkt_type_o` hold stable until yumi, even if higher-priority packets arrive.
- On yumi: `last_grant_r` ← granted channel and the lock clears. The next grant is computed the same cycle from post-dequeue buffer state.
- FSM: `e_idle` (no buffer valid, `pkt_v_o`=0) → `e_grant` (`pkt_v_o`=1, lock held).
  - `e_grant` stays in `e_grant` on yumi if any buffer is still non-empty, else goes to `e_idle`.
  - `e_grant` → `e_grant` holding the lock without yumi.
- Enqueue and dequeue on the same buffer in the same cycle are legal at any occupancy except full. A full buffer's `ready_o` is already low.
- An asserted `pkt_yumi_i` with `pkt_v_o`=0 is a protocol error, covered by an assertion in simulation only; the buffers are unaffected.
- When `pkt_v_o`=0, `pkt_o` and `pkt_type_o` are driven to 0.

## Timing
- Reset values: `pkt_v_o`=0, `pkt_o`=0, `pkt_type_o`=0, `idle_o`=1, all `*_ready_o`=0 while `reset_i` is high.
  - Readies go to 1 on the first cycle after `reset_i` deasserts.
  - `last_grant_r`=stat, so the first grant checks data first. Lock clear, buffers empty.
- Reset mid-operation discards all buffered packets and the lock within one cycle. Nothing is output on the cycle following reset.
- Latency: a packet accepted at cycle N is visible on `pkt_o` at N+1 at earliest. There is no combinational bypass.
- Throughput: 1 packet/cycle aggregate. A single active channel sustains 1/cycle with the consumer yumi-ing every cycle, because the buffers are 2-deep.
- Fairness: with all three channels backlogged, grants go D,T,S,D,T,S. Each channel waits at most 2 grants.
- `idle_o` is registered-equivalent: it is derived from buffer state only, with no input-to-output path.

## Structure
- `bp_fe_pkg`: add `bp_fe_lce_pkt_type_e` (`e_fe_pkt_data`=0, `e_fe_pkt_tag`=1, `e_fe_pkt_stat`=2) and the FSM enum `bp_fe_lce_arb_state_e`.
- Sub-module: one `bsg_two_fifo` per channel, 3 instances.
- The arbiter, lock and `last_grant_r` are local logic in this module.

## Test plan
- Reset, then data pkt 0xA5 at cycle 1 → `pkt_v_o`=1, `pkt_type_o`=0, `pkt_o`=0xA5 at cycle 2. `idle_o`=1 after yumi.
- Three channels each hold 3 packets, yumi every cycle → type sequence 0,1,2,0,1,2,0,1,2, no bubbles.
- Data pkt pending with no yumi for 5 cycles while a tag pkt arrives at cycle 2 → `pkt_o`/`pkt_type_o` stay data for all 5 cycles. Tag is granted on the cycle after yumi.
- Consumer stalls, data sender pushes 3 packets → `data_mem_pkt_ready_o`=0 after the 2nd. The 3rd is accepted the cycle after the first yumi, and order is preserved.
- Assert `reset_i` for 1 cycle with 2 tag + 1 stat buffered → `pkt_v_o`=0 and `idle_o`=1 the next cycle. Readies are 0 during reset and 1 after.
- Stat pkt with `stat_pkt_width_p` < `pkt_width_lp` → upper bits of `pkt_o` read 0.
